ifu_fetch_buf: RTL
==================

Name: ifu_fetch_buf

Overview:
Fetch buffer between the F2 stage of the fetch pipe and the instruction aligner. It queues fetch packets that hit in the I-cache or ICCM. It presents the two oldest packets to the aligner and pops up to two packets per cycle. It returns the actual pop count to fetch control as ifu_fb_consume1 / ifu_fb_consume2, which closes the fetch-buffer mass-balance loop.

Parameters:
DEPTH, 4, number of packet entries; power of two, at least 2.
DATA_W, 64, fetch packet data width in bits.

Ports:
clk  input  1  core clock
rst_l  input  1  asynchronous active-low reset
ifc_fetch_req_f2  input  1  F2 fetch request valid
ic_hit_f2  input  1  F2 packet data valid (cache/ICCM hit)
ic_data_f2  input  DATA_W  F2 fetch packet data
ifc_fetch_addr_f2  input  31  F2 fetch address [31:1]
exu_flush_final  input  1  pipeline flush
dec_takenbr  input  1  decode-stage taken branch; flushes the buffer
aln_pop  input  2  aligner pop request: 0, 1 or 2 packets
fb_vld  output  2  bit0: head entry valid; bit1: head+1 valid
fb_data0  output  DATA_W  head packet data
fb_data1  output  DATA_W  head+1 packet data
fb_addr0  output  31  head packet address
fb_addr1  output  31  head+1 packet address
fb_count  output  clog2(DEPTH)+1  occupancy
fb_full  output  1  occupancy equals DEPTH
ifu_fb_consume1  output  1  exactly one packet popped this cycle
ifu_fb_consume2  output  1  two packets popped this cycle
fb_overflow  output  1  sticky error: write dropped because the buffer was full

Behaviour:
- Storage: DEPTH-entry circular array of {data, addr}.
  - rd_ptr and wr_ptr are clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is a separate register, range 0..DEPTH.
- Reset (async assert, sync deassert by flop): rd_ptr = 0, wr_ptr = 0, count = 0, fb_overflow = 0.
  - Outputs after reset: fb_vld = 0, fb_full = 0, consume1 = 0, consume2 = 0.
  - Entry data is not reset; fb_data/fb_addr are don't-care while their fb_vld bit is 0.
- flush = exu_flush_final | dec_takenbr.
- Write request: wr = ifc_fetch_req_f2 & ic_hit_f2 & ~flush.
- Effective pop: pop_eff = 0 when flush; otherwise min(aln_pop, count). A request of 3 is treated as 2.
- Consume outputs are combinational from the current cycle:
  - ifu_fb_consume1 = (pop_eff == 1).
  - ifu_fb_consume2 = (pop_eff == 2).
  - They are mutually exclusive.
- Write acceptance: wr_ok = wr & ((count − pop_eff) < DEPTH). A pop in the same cycle frees space, so a full buffer accepts a write when pop_eff ≥ 1.
- Dropped write: wr & ~wr_ok sets fb_overflow. It stays set until reset. The entry and pointers are unchanged.
- Update on clk rising edge:
  - Flush: rd_ptr ← 0, wr_ptr ← 0, count ← 0. Any concurrent write or pop is discarded.
  - Otherwise:
    - rd_ptr ← rd_ptr + pop_eff (mod DEPTH).
    - If wr_ok: entry[wr_ptr] ← {ic_data_f2, ifc_fetch_addr_f2}; wr_ptr ← wr_ptr + 1.
    - count ← count + wr_ok − pop_eff.
- Head outputs, all combinational from registered state:
  - fb_vld[0] = (count ≥ 1); fb_vld[1] = (count ≥ 2).
  - fb_data0/fb_addr0 = entry[rd_ptr]; fb_data1/fb_addr1 = entry[rd_ptr+1 mod DEPTH].
- Latency: write-to-visible is 1 cycle; there is no bypass of F2 data to the head.
- fb_full = (count == DEPTH); fb_count = count.
- Empty with aln_pop ≠ 0: no pop, both consume signals 0, no underflow.
- Simultaneous write and 2-pop with count = 2: buffer ends with count = 1, holding the new packet at head.
- Fetch-control interface rule: this block must be the sole source of ifu_fb_consume1/2. Fetch control's model holds exactly while no writes are dropped, so fb_overflow must stay 0 in all legal traffic. Assert this in simulation.

Test Plan:
- Reset, then 3 hits at addresses 0x100, 0x108, 0x110 with aln_pop = 0 → count = 3; fb_addr0 = 0x100, fb_addr1 = 0x108; consume signals 0.
- count = 3, aln_pop = 2 with no write → consume2 = 1 for that cycle; next cycle count = 1, fb_addr0 = 0x110, fb_vld = 2'b01.
- Fill to DEPTH = 4, then write with aln_pop = 0 → write dropped, fb_overflow = 1, count stays 4. Repeat the write with aln_pop = 1 → accepted, consume1 = 1, count stays 4.
- count = 1, aln_pop = 2 → pop_eff = 1: consume1 = 1, consume2 = 0, count = 0. Then, with count = 0, aln_pop = 1 → no consume.
- count = 3, exu_flush_final = 1 together with a write and aln_pop = 2 → both consume signals 0; next cycle count = 0, fb_vld = 0. The following hit lands at entry 0 and is visible one cycle later.
- Wrap-around: 10 write/1-pop cycles at steady count = 2 → addresses appear at the head in order with no loss across the pointer wrap. Asynchronous reset asserted mid-stream → fb_vld = 0 immediately.

Source files
------------

// File: rtl/ifu_fetch_buf.sv
// ifu_fetch_buf: fetch-packet queue between F2 and the aligner.
// Pops up to two packets per cycle and reports the pop count back to fetch control.
module ifu_fetch_buf #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 64,
  parameter bit OVF_CHK = 1'b1,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              ifc_fetch_req_f2,
  input  logic              ic_hit_f2,
  input  logic [DATA_W-1:0] ic_data_f2,
  input  logic [30:0]       ifc_fetch_addr_f2,
  input  logic              exu_flush_final,
  input  logic              dec_takenbr,
  input  logic [1:0]        aln_pop,
  output logic [1:0]        fb_vld,
  output logic [DATA_W-1:0] fb_data0,
  output logic [DATA_W-1:0] fb_data1,
  output logic [30:0]       fb_addr0,
  output logic [30:0]       fb_addr1,
  output logic [CW-1:0]     fb_count,
  output logic              fb_full,
  output logic              ifu_fb_consume1,
  output logic              ifu_fb_consume2,
  output logic              fb_overflow
);
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [30:0]       addr_q [DEPTH];
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d, rd1;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              flush, wr, wr_ok;
  logic [1:0]        pop_req, pop_eff;

  always_comb begin
    flush   = exu_flush_final | dec_takenbr;
    wr      = ifc_fetch_req_f2 & ic_hit_f2 & ~flush;
    pop_req = aln_pop[1] ? 2'd2 : aln_pop;
    pop_eff = flush ? 2'd0 : (CW'(pop_req) > count_q) ? 2'(count_q) : pop_req;
    // a same-cycle pop frees a slot, so a full buffer can still accept
    wr_ok   = wr & ((count_q - CW'(pop_eff)) < CW'(DEPTH));
    rd_d    = flush ? '0 : rd_q + PW'(pop_eff);
    wr_d    = flush ? '0 : wr_q + PW'(wr_ok);
    count_d = flush ? '0 : count_q + CW'(wr_ok) - CW'(pop_eff);
    ovf_d   = ovf_q | (wr & ~wr_ok);
    rd1     = rd_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      data_q[wr_q] <= ic_data_f2;
      addr_q[wr_q] <= ifc_fetch_addr_f2;
    end
  end

  assign fb_vld          = {count_q >= CW'(2), count_q != '0};
  assign fb_data0        = data_q[rd_q];
  assign fb_data1        = data_q[rd1];
  assign fb_addr0        = addr_q[rd_q];
  assign fb_addr1        = addr_q[rd1];
  assign fb_count        = count_q;
  assign fb_full         = count_q == CW'(DEPTH);
  assign ifu_fb_consume1 = pop_eff == 2'd1;
  assign ifu_fb_consume2 = pop_eff == 2'd2;
  assign fb_overflow     = ovf_q;

  // fetch control's occupancy model breaks if a write is ever dropped
  a_no_drop: assert property (@(posedge clk) disable iff (!rst_l) !(OVF_CHK && wr && !wr_ok));
  a_cons_excl: assert property (@(posedge clk) disable iff (!rst_l) !(ifu_fb_consume1 && ifu_fb_consume2));
endmodule
